// File: rtl/coin_pkg.sv
// Shared coin types, denomination values, FSM states and tally layout for change_dispenser.
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_DOLLAR  = 2'd0,
        COIN_QUARTER = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_NICKEL  = 2'd3
    } coin_t;

    localparam int unsigned NUM_COINS = 4;

    localparam logic [6:0] VALUE_DOLLAR  = 7'd100;
    localparam logic [6:0] VALUE_QUARTER = 7'd25;
    localparam logic [6:0] VALUE_DIME    = 7'd10;
    localparam logic [6:0] VALUE_NICKEL  = 7'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_DONE
    } state_t;

    localparam int unsigned TALLY_FIELD_W     = 7;
    localparam int unsigned TALLY_W           = 4 * TALLY_FIELD_W;
    localparam int unsigned TALLY_DOLLAR_LSB  = 21;
    localparam int unsigned TALLY_QUARTER_LSB = 14;
    localparam int unsigned TALLY_DIME_LSB    = 7;
    localparam int unsigned TALLY_NICKEL_LSB  = 0;

    function automatic logic [6:0] coin_value(input coin_t c);
        case (c)
            COIN_DOLLAR:  return VALUE_DOLLAR;
            COIN_QUARTER: return VALUE_QUARTER;
            COIN_DIME:    return VALUE_DIME;
            default:      return VALUE_NICKEL;
        endcase
    endfunction

    function automatic int unsigned tally_lsb(input coin_t c);
        case (c)
            COIN_DOLLAR:  return TALLY_DOLLAR_LSB;
            COIN_QUARTER: return TALLY_QUARTER_LSB;
            COIN_DIME:    return TALLY_DIME_LSB;
            default:      return TALLY_NICKEL_LSB;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational pick of the largest available denomination not exceeding the amount owed.
import coin_pkg::*;

module coin_select #(
    parameter int unsigned AMT_W = 9
) (
    input  logic [AMT_W-1:0]     remaining,
    input  logic [NUM_COINS-1:0] avail,
    output logic [1:0]           coin_sel,
    output logic                 found
);

    // Coin encodings run largest to smallest, so the first hit wins.
    always_comb begin
        coin_sel = 2'd0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (!found && avail[i] &&
                remaining >= AMT_W'(coin_value(coin_t'(i[1:0])))) begin
                coin_sel = i[1:0];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time, largest denomination first, with hopper handshake.
// Optional per-denomination inventory and restock port: define COIN_INVENTORY_EN.
import coin_pkg::*;

module change_dispenser #(
    parameter int unsigned AMT_W    = 9,
    parameter int unsigned INV_W    = 8,
    parameter int unsigned INV_INIT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_ack,
`ifdef COIN_INVENTORY_EN
    input  logic             restock,
`endif
    output logic             busy,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    output logic [27:0]      tally
);

    if (AMT_W < 7 || INV_W == 0 || INV_INIT >= (32'd1 << INV_W)) begin : g_bad_params
        $error("change_dispenser: AMT_W too narrow or INV_INIT does not fit in INV_W");
    end

    state_t                 state_q, state_d;
    logic [AMT_W-1:0]       remaining_q;
    logic [TALLY_W-1:0]     tally_q;
    coin_t                  sel_q;
    logic                   error_q;

    logic [NUM_COINS-1:0]   avail;
    logic [1:0]             found_sel;
    logic                   found;

    logic                   accept, reject, latch_sel, pay, err_set, err_clr;

    coin_select #(.AMT_W(AMT_W)) u_select (
        .remaining (remaining_q),
        .avail     (avail),
        .coin_sel  (found_sel),
        .found     (found)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        latch_sel = 1'b0;
        pay       = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((amount % AMT_W'(5)) == '0) begin
                        accept  = 1'b1;
                        state_d = ST_SELECT;
                    end else begin
                        reject  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    err_clr = 1'b1;
                    state_d = ST_DONE;
                end else if (found) begin
                    latch_sel = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    err_set = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (coin_ack) begin
                    pay     = 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            tally_q     <= '0;
            sel_q       <= COIN_DOLLAR;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                remaining_q <= amount;
                tally_q     <= '0;
                error_q     <= 1'b0;
            end
            if (reject) begin
                remaining_q <= amount;
                error_q     <= 1'b1;
            end
            if (latch_sel) sel_q <= coin_t'(found_sel);
            if (pay) begin
                remaining_q <= remaining_q - AMT_W'(coin_value(sel_q));
                tally_q[tally_lsb(sel_q) +: TALLY_FIELD_W] <=
                    tally_q[tally_lsb(sel_q) +: TALLY_FIELD_W] + 7'd1;
            end
            if (err_set) error_q <= 1'b1;
            if (err_clr) error_q <= 1'b0;
        end
    end

`ifdef COIN_INVENTORY_EN
    logic [INV_W-1:0] inv_q [NUM_COINS];

    // Restock overrides a same-cycle payout decrement.
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            for (int unsigned i = 0; i < NUM_COINS; i++) inv_q[i] <= INV_W'(INV_INIT);
        end else if (pay) begin
            inv_q[sel_q] <= inv_q[sel_q] - INV_W'(1);
        end
    end

    always_comb begin
        avail = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) avail[i] = (inv_q[i] != '0);
    end
`else
    assign avail = '1;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign coin_req  = (state_q == ST_REQ);
    assign done      = (state_q == ST_DONE);
    assign coin_sel  = sel_q;
    assign error     = error_q;
    assign remaining = remaining_q;
    assign tally     = tally_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a greedy coin-change reference model.
module tb_change_dispenser;

`ifdef COIN_INVENTORY_EN
    localparam int unsigned INV_INIT_TB = 1;
`else
    localparam int unsigned INV_INIT_TB = 20;
`endif

    logic        clk = 1'b0;
    logic        rst, start, coin_ack, restock;
    logic [8:0]  amount;
    logic        busy, coin_req, done, error;
    logic [1:0]  coin_sel;
    logic [8:0]  remaining;
    logic [27:0] tally;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_seq, exp_seq;
    int          got_cnt, exp_cnt, got_done_cyc, got_first_req;
    int          gap_bad, stable_bad, busy_bad;
    logic        got_err, got_post_busy, got_post_done;
    logic [8:0]  got_rem;
    logic [27:0] got_tally, exp_tal;
    bit          exp_err;
    int          exp_rem;
    int          inv_m[4];

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(9), .INV_W(8), .INV_INIT(INV_INIT_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .amount    (amount),
        .coin_ack  (coin_ack),
`ifdef COIN_INVENTORY_EN
        .restock   (restock),
`endif
        .busy      (busy),
        .coin_req  (coin_req),
        .coin_sel  (coin_sel),
        .done      (done),
        .error     (error),
        .remaining (remaining),
        .tally     (tally)
    );

    function automatic bit avail_m(input int c);
`ifdef COIN_INVENTORY_EN
        return inv_m[c] > 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_restock();
        for (int c = 0; c < 4; c++) inv_m[c] = INV_INIT_TB;
    endfunction

    // Greedy change-making from the denomination rules, tracking stock.
    function automatic void model(input int amt);
        int vals[4] = '{100, 25, 10, 5};
        int n[4]    = '{0, 0, 0, 0};
        int pick;
        exp_seq = '0;
        exp_cnt = 0;
        exp_rem = amt;
        exp_tal = '0;
        if (amt % 5 != 0) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (exp_rem == 0) break;
            pick = -1;
            for (int c = 0; c < 4; c++)
                if (pick < 0 && vals[c] <= exp_rem && avail_m(c)) pick = c;
            if (pick < 0) begin
                exp_err = 1'b1;
                break;
            end
            exp_seq[2*exp_cnt +: 2] = 2'(pick);
            exp_cnt++;
            exp_rem -= vals[pick];
            n[pick]++;
            inv_m[pick]--;
        end
        exp_tal = {7'(n[0]), 7'(n[1]), 7'(n[2]), 7'(n[3])};
    endfunction

    task automatic do_restock();
        restock = 1'b1;
        @(posedge clk); #1;
        restock = 1'b0;
        model_restock();
    endtask

    // Drives one payout and acts as the hopper; cycle 0 is the sample after the start edge.
    task automatic do_payout(input logic [8:0] amt, input int min_w, input int max_w, input bit poke);
        int   wait_cnt, delay, last_ack;
        bit   in_req, poked;
        logic [1:0] req_sel;
        got_seq = '0; got_cnt = 0; got_done_cyc = -1; got_first_req = -1;
        gap_bad = 0; stable_bad = 0; busy_bad = 0;
        in_req = 1'b0; poked = 1'b0; last_ack = -1; wait_cnt = 0; delay = 0; req_sel = 2'd0;
        start  = 1'b1;
        amount = amt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            coin_ack = 1'b0;
            start    = 1'b0;
            if (done) begin
                got_done_cyc = cyc;
                got_err      = error;
                got_rem      = remaining;
                got_tally    = tally;
                break;
            end
            if (!busy) busy_bad++;
            if (coin_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    wait_cnt = 0;
                    req_sel  = coin_sel;
                    delay    = $urandom_range(max_w, min_w);
                    if (got_cnt < 32) got_seq[2*got_cnt +: 2] = coin_sel;
                    got_cnt++;
                    if (last_ack < 0) begin
                        if (got_first_req < 0) got_first_req = cyc;
                    end else if (cyc - last_ack != 2) begin
                        gap_bad++;
                    end
                end else if (coin_sel !== req_sel) begin
                    stable_bad++;
                end
                if (poke && !poked && wait_cnt == 1) begin
                    start  = 1'b1;
                    amount = 9'd35;
                    poked  = 1'b1;
                end
                if (wait_cnt == delay) begin
                    coin_ack = 1'b1;
                    last_ack = cyc;
                    in_req   = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else if (in_req) begin
                stable_bad++;
            end
            @(posedge clk); #1;
        end
        coin_ack = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (got_done_cyc < 0) begin
            n_fail++;
            $display("FAIL payout_timeout amount=%0d: no done within 400 cycles", amt);
        end
        @(posedge clk); #1;
        got_post_busy = busy;
        got_post_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; coin_ack = 1'b0; restock = 1'b0; amount = '0;
        model_restock();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (coin_req !== 1'b0)  begin n_fail++; $display("FAIL reset_coin_req got=%b exp=0", coin_req); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (error !== 1'b0)     begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
        n_checks++; if (coin_sel !== 2'd0)  begin n_fail++; $display("FAIL reset_coin_sel got=%0d exp=0", coin_sel); end
        n_checks++; if (remaining !== 9'd0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
        n_checks++; if (tally !== 28'd0)    begin n_fail++; $display("FAIL reset_tally got=%h exp=0", tally); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_payout_165();
        model(165);
        do_payout(9'd165, 0, 2, 1'b0);
        n_checks++; if (got_cnt !== exp_cnt)     begin n_fail++; $display("FAIL p165_count got=%0d exp=%0d", got_cnt, exp_cnt); end
        n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL p165_seq got=%h exp=%h", got_seq, exp_seq); end
        n_checks++; if (got_err !== exp_err)     begin n_fail++; $display("FAIL p165_error got=%b exp=%b", got_err, exp_err); end
        n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL p165_remaining got=%0d exp=%0d", got_rem, exp_rem); end
        n_checks++; if (got_tally !== exp_tal)   begin n_fail++; $display("FAIL p165_tally got=%h exp=%h", got_tally, exp_tal); end
        n_checks++; if (got_first_req !== 1)     begin n_fail++; $display("FAIL p165_first_req_cycle got=%0d exp=1", got_first_req); end
        n_checks++; if (gap_bad !== 0)           begin n_fail++; $display("FAIL p165_req_gap got=%0d bad gaps exp=0", gap_bad); end
        n_checks++; if (busy_bad !== 0)          begin n_fail++; $display("FAIL p165_busy_low got=%0d cycles exp=0", busy_bad); end
        n_checks++; if (got_post_busy !== 1'b0)  begin n_fail++; $display("FAIL p165_busy_after_done got=%b exp=0", got_post_busy); end
        n_checks++; if (got_post_done !== 1'b0)  begin n_fail++; $display("FAIL p165_done_width got=%b exp=0", got_post_done); end
`ifndef COIN_INVENTORY_EN
        n_checks++; if (got_seq !== 64'h394)     begin n_fail++; $display("FAIL p165_seq_const got=%h exp=394", got_seq); end
        n_checks++; if (got_tally !== {7'd1, 7'd2, 7'd1, 7'd1}) begin n_fail++; $display("FAIL p165_tally_const got=%h", got_tally); end
`endif
    endtask

    task automatic test_zero_and_reject();
        model(0);
        do_payout(9'd0, 0, 0, 1'b0);
        n_checks++; if (got_done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=1", got_done_cyc); end
        n_checks++; if (got_err !== 1'b0)   begin n_fail++; $display("FAIL zero_error got=%b exp=0", got_err); end
        n_checks++; if (got_cnt !== 0)      begin n_fail++; $display("FAIL zero_coin_count got=%0d exp=0", got_cnt); end
        model(37);
        do_payout(9'd37, 0, 0, 1'b0);
        n_checks++; if (got_done_cyc !== 0) begin n_fail++; $display("FAIL reject_done_cycle got=%0d exp=0", got_done_cyc); end
        n_checks++; if (got_err !== 1'b1)   begin n_fail++; $display("FAIL reject_error got=%b exp=1", got_err); end
        n_checks++; if (got_rem !== 9'd37)  begin n_fail++; $display("FAIL reject_remaining got=%0d exp=37", got_rem); end
        n_checks++; if (got_cnt !== 0)      begin n_fail++; $display("FAIL reject_coin_count got=%0d exp=0", got_cnt); end
    endtask

    task automatic test_start_while_busy();
        model(185);
        do_payout(9'd185, 3, 5, 1'b1);
        n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL busy_start_seq got=%h exp=%h", got_seq, exp_seq); end
        n_checks++; if (got_cnt !== exp_cnt)     begin n_fail++; $display("FAIL busy_start_count got=%0d exp=%0d", got_cnt, exp_cnt); end
        n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL busy_start_remaining got=%0d exp=%0d", got_rem, exp_rem); end
        n_checks++; if (got_tally !== exp_tal)   begin n_fail++; $display("FAIL busy_start_tally got=%h exp=%h", got_tally, exp_tal); end
    endtask

    task automatic test_slow_ack();
        model(40);
        do_payout(9'd40, 10, 10, 1'b0);
        n_checks++; if (stable_bad !== 0)        begin n_fail++; $display("FAIL slow_ack_stable got=%0d glitches exp=0", stable_bad); end
        n_checks++; if (gap_bad !== 0)           begin n_fail++; $display("FAIL slow_ack_gap got=%0d exp=0", gap_bad); end
        n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL slow_ack_seq got=%h exp=%h", got_seq, exp_seq); end
        n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL slow_ack_remaining got=%0d exp=%0d", got_rem, exp_rem); end
    endtask

    task automatic test_stray_ack();
        for (int k = 0; k < 3; k++) begin
            coin_ack = 1'b1;
            @(posedge clk); #1;
            n_checks++; if (coin_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req got=%b exp=0", coin_req); end
            n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL stray_ack_busy got=%b exp=0", busy); end
        end
        coin_ack = 1'b0;
        n_checks++; if (remaining !== 9'(exp_rem)) begin n_fail++; $display("FAIL stray_ack_remaining got=%0d exp=%0d", remaining, exp_rem); end
        n_checks++; if (tally !== exp_tal)         begin n_fail++; $display("FAIL stray_ack_tally got=%h exp=%h", tally, exp_tal); end
    endtask

`ifdef COIN_INVENTORY_EN
    task automatic test_inventory();
        do_restock();
        model(50);
        do_payout(9'd50, 0, 1, 1'b0);
        n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL inv50_seq got=%h exp=%h", got_seq, exp_seq); end
        n_checks++; if (got_err !== exp_err)     begin n_fail++; $display("FAIL inv50_error got=%b exp=%b", got_err, exp_err); end
        n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL inv50_remaining got=%0d exp=%0d", got_rem, exp_rem); end
        do_restock();
        model(200);
        do_payout(9'd200, 0, 1, 1'b0);
        n_checks++; if (got_seq !== 64'hE4)  begin n_fail++; $display("FAIL inv200_seq got=%h exp=e4", got_seq); end
        n_checks++; if (got_err !== 1'b1)    begin n_fail++; $display("FAIL inv200_error got=%b exp=1", got_err); end
        n_checks++; if (got_rem !== 9'd60)   begin n_fail++; $display("FAIL inv200_remaining got=%0d exp=60", got_rem); end
        do_restock();
        model(60);
        do_payout(9'd60, 0, 1, 1'b0);
        n_checks++; if (got_seq !== 64'h39)  begin n_fail++; $display("FAIL inv60_seq got=%h exp=39", got_seq); end
        n_checks++; if (got_err !== 1'b1)    begin n_fail++; $display("FAIL inv60_error got=%b exp=1", got_err); end
        n_checks++; if (got_rem !== 9'd20)   begin n_fail++; $display("FAIL inv60_remaining got=%0d exp=20", got_rem); end
    endtask
`endif

    task automatic test_random();
        int amt;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(3, 0) != 0) amt = $urandom_range(102, 0) * 5;
            else                           amt = $urandom_range(511, 0);
`ifdef COIN_INVENTORY_EN
            if ($urandom_range(2, 0) == 0) do_restock();
`endif
            model(amt);
            do_payout(9'(amt), 0, 3, 1'b0);
            n_checks++; if (got_err !== exp_err)     begin n_fail++; $display("FAIL rand_error amount=%0d got=%b exp=%b", amt, got_err, exp_err); end
            n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL rand_remaining amount=%0d got=%0d exp=%0d", amt, got_rem, exp_rem); end
            n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL rand_seq amount=%0d got=%h exp=%h", amt, got_seq, exp_seq); end
            n_checks++; if (got_cnt !== exp_cnt)     begin n_fail++; $display("FAIL rand_count amount=%0d got=%0d exp=%0d", amt, got_cnt, exp_cnt); end
            if (amt % 5 == 0) begin
                n_checks++; if (got_tally !== exp_tal) begin n_fail++; $display("FAIL rand_tally amount=%0d got=%h exp=%h", amt, got_tally, exp_tal); end
                n_checks++; if (gap_bad !== 0)         begin n_fail++; $display("FAIL rand_req_gap amount=%0d got=%0d exp=0", amt, gap_bad); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        model(200);
        do_payout(9'd200, 0, 0, 1'b0);
        start  = 1'b1;
        amount = 9'd165;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 10 && !coin_req; k++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (coin_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_seen got=%b exp=1", coin_req); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (coin_req !== 1'b0)  begin n_fail++; $display("FAIL rstmid_coin_req got=%b exp=0", coin_req); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (remaining !== 9'd0) begin n_fail++; $display("FAIL rstmid_remaining got=%0d exp=0", remaining); end
        n_checks++; if (tally !== 28'd0)    begin n_fail++; $display("FAIL rstmid_tally got=%h exp=0", tally); end
        model_restock();
        model(50);
        do_payout(9'd50, 0, 1, 1'b0);
        n_checks++; if (got_seq !== exp_seq)     begin n_fail++; $display("FAIL rstmid_after_seq got=%h exp=%h", got_seq, exp_seq); end
        n_checks++; if (got_rem !== 9'(exp_rem)) begin n_fail++; $display("FAIL rstmid_after_remaining got=%0d exp=%0d", got_rem, exp_rem); end
        n_checks++; if (got_err !== exp_err)     begin n_fail++; $display("FAIL rstmid_after_error got=%b exp=%b", got_err, exp_err); end
    endtask

    initial begin
        test_reset();
        test_payout_165();
        test_zero_and_reject();
        test_start_while_busy();
        test_slow_ack();
        test_stray_ack();
`ifdef COIN_INVENTORY_EN
        test_inventory();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
